// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: packs decoded RV32I fields plus a generator-unit immediate
// into a 32-bit instruction word. This is the inverse of the pipeline's
// immediate generator.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    request handshake; in_ready = !out_valid || out_ready
//   in_opcode..in_imm    decoded instruction fields and immediate
//   out_valid/out_ready  encoded-word handshake (single registered stage)
//   out_instr, out_err   encoded word; out_err marks a substituted NOP
//   out_addr             byte address of out_instr (running counter)
//   err_seen             sticky error flag, cleared by reset or addr_load
//   addr_load(_val)      reload the address counter
//   chk_fail             only with IMM_ENC_CHECK_EN: re-decode mismatch pulse
//
// Optional feature macro: IMM_ENC_CHECK_EN
module imm_instr_encoder #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_seen,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_load_val
`ifdef IMM_ENC_CHECK_EN
  ,
  output logic              chk_fail
`endif
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [2:0] {FmtI, FmtShift, FmtS, FmtB, FmtJ, FmtR, FmtBad} fmt_e;

  fmt_e        fmt;
  logic        fits12, fits20, fits_sh, imm_ok;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        accept, out_hs;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;
  logic              err_seen_q, err_seen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign in_ready = rst_n & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  // A value fits a signed N-bit field when all bits above N-1 equal the sign bit.
  assign fits12  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits20  = (&in_imm[31:19]) | ~(|in_imm[31:19]);
  assign fits_sh = ~(|in_imm[31:5]);

  always_comb begin
    fmt = FmtBad;
    case (in_opcode)
      7'b0000011, 7'b1100111: fmt = FmtI;
      7'b0010011: fmt = (in_funct3 == 3'b001 || in_funct3 == 3'b101) ? FmtShift : FmtI;
      7'b0100011: fmt = FmtS;
      7'b1100011: fmt = FmtB;
      7'b1101111: fmt = FmtJ;
      7'b0110011: fmt = FmtR;
      default:    fmt = FmtBad;
    endcase
  end

  always_comb begin
    enc_instr = Nop;
    imm_ok    = 1'b0;
    case (fmt)
      FmtI: begin
        imm_ok    = fits12;
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FmtShift: begin
        imm_ok    = fits_sh;
        enc_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FmtS: begin
        imm_ok    = fits12;
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FmtB: begin
        // Immediate is already in halfword units, so in_imm[11] is offset bit 12.
        imm_ok    = fits12;
        enc_instr = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3, in_imm[3:0],
                     in_imm[10], in_opcode};
      end
      FmtJ: begin
        imm_ok    = fits20;
        enc_instr = {in_imm[19], in_imm[9:0], in_imm[10], in_imm[18:11], in_rd, in_opcode};
      end
      FmtR: begin
        imm_ok    = 1'b1;
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: begin
        imm_ok    = 1'b0;
        enc_instr = Nop;
      end
    endcase
    enc_err = ~imm_ok;
    if (enc_err) enc_instr = Nop;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    addr_d      = addr_q;
    err_seen_d  = err_seen_q;
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = enc_instr;
      err_d       = enc_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A word completing alongside a load keeps its pre-load address.
    if (addr_load)   addr_d = addr_load_val;
    else if (out_hs) addr_d = addr_q + ADDR_W'(4);
    if (addr_load)             err_seen_d = 1'b0;
    if (accept && enc_err)     err_seen_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      err_seen_q  <= 1'b0;
      addr_q      <= RESET_ADDR;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      err_seen_q  <= err_seen_d;
      addr_q      <= addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign err_seen  = err_seen_q;
  assign out_addr  = addr_q;

`ifdef IMM_ENC_CHECK_EN
  fmt_e        fmt_q;
  logic [31:0] imm_q;
  logic        chk_pend_q;
  logic        chk_fail_q;
  logic [31:0] dec_imm;

  // Immediate generator equations applied to the held word.
  always_comb begin
    dec_imm = '0;
    case (fmt_q)
      FmtI:     dec_imm = {{20{instr_q[31]}}, instr_q[31:20]};
      FmtShift: dec_imm = {27'b0, instr_q[24:20]};
      FmtS:     dec_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      FmtB:     dec_imm = {{20{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                           instr_q[11:8]};
      FmtJ:     dec_imm = {{12{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                           instr_q[30:21]};
      default:  dec_imm = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fmt_q      <= FmtBad;
      imm_q      <= '0;
      chk_pend_q <= 1'b0;
      chk_fail_q <= 1'b0;
    end else begin
      chk_pend_q <= accept & ~enc_err & (fmt != FmtR);
      if (accept) begin
        fmt_q <= fmt;
        imm_q <= in_imm;
      end
      chk_fail_q <= chk_pend_q & (dec_imm != imm_q);
    end
  end

  assign chk_fail = chk_fail_q;
`endif

endmodule

// File: tb/tb_imm_instr_encoder.sv
module tb_imm_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_seen;
  logic        addr_load;
  logic [31:0] addr_load_val;
`ifdef IMM_ENC_CHECK_EN
  logic        chk_fail;
`endif

  always #5 clk = ~clk;

  imm_instr_encoder #(
    .ADDR_W     (32),
    .RESET_ADDR (32'h0000_0000)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_rd         (in_rd),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_funct3     (in_funct3),
    .in_funct7     (in_funct7),
    .in_imm        (in_imm),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_addr      (out_addr),
    .out_err       (out_err),
    .err_seen      (err_seen),
    .addr_load     (addr_load),
    .addr_load_val (addr_load_val)
`ifdef IMM_ENC_CHECK_EN
    ,
    .chk_fail      (chk_fail)
`endif
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } sb_t;

  sb_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_addr;
  logic [31:0] exp_instr_in;
  logic        exp_err_in;
  logic        last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: observe at negedge, update bench model at posedge, return 1 after it.
  task automatic step();
    logic hs;
    sb_t  e;
    @(negedge clk);
    hs       = out_valid & out_ready;
    last_acc = in_valid & in_ready;
`ifdef IMM_ENC_CHECK_EN
    check_eq("chk_fail", {31'b0, chk_fail}, 32'd0);
`endif
    if (hs) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_instr", out_instr, e.instr);
        check_eq("sb_err", {31'b0, out_err}, {31'b0, e.err});
        check_eq("sb_addr", out_addr, model_addr);
      end
    end
    if (last_acc) sb_q.push_back('{instr: exp_instr_in, err: exp_err_in});
    @(posedge clk);
    if (!rst_n) begin
      sb_q.delete();
      model_addr = 32'h0;
    end else if (addr_load) begin
      model_addr = addr_load_val;
    end else if (hs) begin
      model_addr = model_addr + 32'd4;
    end
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] exp_i, input logic exp_e);
    in_valid     = 1'b1;
    in_opcode    = op;
    in_rd        = rd;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_funct3    = f3;
    in_funct7    = f7;
    in_imm       = imm;
    exp_instr_in = exp_i;
    exp_err_in   = exp_e;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] exp_i, input logic exp_e);
    bit done = 0;
    set_in(op, rd, rs1, rs2, f3, f7, imm, exp_i, exp_e);
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      done = last_acc;
    end
    if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    model_addr    = 32'h0;
    last_acc      = 1'b0;
    rst_n         = 1'b0;
    out_ready     = 1'b1;
    addr_load     = 1'b0;
    addr_load_val = '0;
    set_in(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h0050_0093, 1'b0);

    // Reset: in_ready must stay low even though out_ready=1 and in_valid=1.
    step();
    step();
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_out_err", {31'b0, out_err}, 32'd0);
    check_eq("rst_err_seen", {31'b0, err_seen}, 32'd0);
    check_eq("rst_out_addr", out_addr, 32'd0);
    rst_n = 1'b1;

    // Legal encodings, back to back at full throughput.
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5,        32'h0050_0093, 1'b0);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,        32'h0020_A423, 1'b0);
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2,      32'hFE00_0EE3, 1'b0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2,        32'h0040_00EF, 1'b0);
    send(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b101, 7'h20, 32'd5,       32'h4052_5193, 1'b0);
    send(7'b0110011, 5'd5, 5'd6, 5'd7, 3'b000, 7'd0, 32'hDEADBEEF, 32'h0073_02B3, 1'b0);
    send(7'b0000011, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd1,      32'hFFF1_2083, 1'b0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2047,     32'h7FF0_0093, 1'b0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2048,   32'h8000_0093, 1'b0);
    send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd524287,   32'h7FFF_F06F, 1'b0);
    send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd524288, 32'h8000_006F, 1'b0);
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd31,       32'h01F0_9093, 1'b0);
    in_valid = 1'b0;
    step();
    check_eq("no_err_seen", {31'b0, err_seen}, 32'd0);

    // Error cases: out-of-range immediates and an unsupported opcode.
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     32'h0000_0013, 1'b1);
    send(7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0,        32'h0000_0013, 1'b1);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd524288,   32'h0000_0013, 1'b1);
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32,       32'h0000_0013, 1'b1);
    send(7'b1100111, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, -32'sd2049,   32'h0000_0013, 1'b1);
    in_valid = 1'b0;
    step();
    check_eq("err_seen_set", {31'b0, err_seen}, 32'd1);
    step();
    step();
    check_eq("err_seen_sticky", {31'b0, err_seen}, 32'd1);

    // Reload address to 0, which also clears err_seen.
    addr_load     = 1'b1;
    addr_load_val = 32'h0;
    step();
    addr_load = 1'b0;
    check_eq("load_err_clr", {31'b0, err_seen}, 32'd0);
    check_eq("load_addr0", out_addr, 32'd0);

    // Backpressure: word A held, word B waits for three cycles.
    out_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    set_in(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("bp_out_instr", out_instr, 32'h0050_0093);
    end
    out_ready = 1'b1;
    step();
    in_valid      = 1'b0;
    addr_load     = 1'b1;
    addr_load_val = 32'h100;
    step();
    addr_load = 1'b0;
    check_eq("load_addr100", out_addr, 32'h100);
    check_eq("drained", {31'b0, out_valid}, 32'd0);

    // Reset while a word is held under backpressure.
    out_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
    in_valid = 1'b0;
    step();
    check_eq("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    check_eq("pre_rst_err_seen", {31'b0, err_seen}, 32'd1);
    rst_n = 1'b0;
    step();
    check_eq("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst2_out_addr", out_addr, 32'd0);
    check_eq("rst2_err_seen", {31'b0, err_seen}, 32'd0);
    check_eq("rst2_out_err", {31'b0, out_err}, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2, 32'hFE00_0EE3, 1'b0);
    in_valid = 1'b0;
    step();
    step();
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Inverse of the pipeline's immediate generator: takes decoded instruction fields plus an immediate value and packs them into a 32-bit RV32I instruction word.
- Sits between the test/boot loader path and instruction memory.
- Valid/ready input, one registered output stage, running write-address counter, and immediate range checking.
- Round-trip invariant: feeding out_instr to the immediate generator returns in_imm for every accepted, non-error request.

Parameters:
- ADDR_W, 32, width of out_addr and addr_load_val.
- RESET_ADDR, 32'h00000000, address counter value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_opcode  input  7  instruction opcode [6:0].
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7 (R-type and shift-immediate only).
- in_imm  input  32  immediate, in generator units (see Behaviour).
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer ready.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  byte address for out_instr.
- out_err  output  1  current out_instr is a substituted NOP due to error.
- err_seen  output  1  sticky: any error emitted since reset or last addr_load.
- addr_load  input  1  load address counter.
- addr_load_val  input  ADDR_W  value loaded into the counter.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_instr=0, out_err=0, err_seen=0, out_addr=RESET_ADDR.
  - Any held word is discarded.
  - in_ready=0 during reset.
- in_ready = !out_valid || out_ready (combinational, single-stage pipeline).
- Latency: word accepted at edge N is presented with out_valid=1 from edge N. Full throughput of one word per cycle when out_ready=1.
- While out_valid && !out_ready: out_instr, out_err and out_valid hold stable.
- Immediate units match the immediate generator's output:
  - I/S: imm[11:0].
  - B: imm[12:1] (halfword offset).
  - J: imm[20:1] (halfword offset).
- Formats and legal in_imm ranges (signed, full 32-bit value checked):
  - 0000011 load, I-type: -2048..2047.
  - 0010011 op-imm, I-type: -2048..2047, except funct3=001/101 (shifts): 0..31, with instr[31:25]=in_funct7.
  - 1100111 jalr, I-type: -2048..2047.
  - 0100011 store, S-type: -2048..2047. imm[11:5]→[31:25], imm[4:0]→[11:7].
  - 1100011 branch, B-type: -2048..2047. in_imm[11]→[31], in_imm[10]→[7], in_imm[9:4]→[30:25], in_imm[3:0]→[11:8].
  - 1101111 jal, J-type: -524288..524287. in_imm[19]→[31], in_imm[18:11]→[19:12], in_imm[10]→[20], in_imm[9:0]→[30:21].
  - 0110011 R-type: in_imm ignored. {funct7, rs2, rs1, funct3, rd, opcode}.
- Unused register fields for a format (e.g. rd for S/B) are not emitted. Their field bits carry immediate or zero per format.
- Error cases: unsupported opcode, or in_imm out of range.
  - out_instr=32'h00000013 (NOP), out_err=1.
  - err_seen set on the accepting edge.
- Address counter:
  - Increments by 4 on each output handshake (out_valid && out_ready), including error words.
  - out_addr shows the counter value, so a word's address is the counter value at its handshake.
  - Counter wraps modulo 2^ADDR_W.
- addr_load at an edge:
  - Counter loads addr_load_val and err_seen clears.
  - Takes precedence over a simultaneous increment; a word completing that cycle uses the pre-load address.
  - Does not disturb out_valid or out_instr.
- Simultaneous output handshake and new input acceptance: new word replaces the old with no bubble.

Optional Feature:
- IMM_ENC_CHECK_EN defined:
  - Adds output chk_fail (1 bit, reset 0).
  - A registered internal re-decode of out_instr (immediate generator equations) is compared with the captured in_imm.
  - chk_fail pulses one cycle after any non-error word whose re-decoded immediate differs. R-type and error words are excluded.
- Macro undefined: port and logic are absent.

Test Plan:
- addi x1,x0,5 (opcode 0010011, rd=1, rs1=0, f3=000, imm=5), out_ready=1 → out_instr=0x00500093, out_addr=0x0, out_err=0; next word at 0x4.
- sw x2,8(x1) (0100011, rs1=1, rs2=2, f3=010, imm=8) → 0x0020A423.
- beq x0,x0 with in_imm=-2 → 0xFE000EE3; jal x1 with in_imm=2 → 0x004000EF.
- addi with imm=2048, then opcode 0110111 → both give out_instr=0x00000013 with out_err=1; err_seen=1 until addr_load.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_instr stable; then two back-to-back words at addr 0x0 and 0x4. addr_load_val=0x100 on the handshake cycle → next out_addr=0x100.
- Reset asserted while out_valid=1 and out_ready=0 → after edge out_valid=0, out_addr=RESET_ADDR, err_seen=0.
